// File: rtl/renode_pkg.sv
// Shared co-simulation types for the Renode bridge blocks.
package renode_pkg;

    // Renode message address field.
    typedef logic [63:0] address_t;

    // One GPIO change record as seen by the message sender.
    typedef struct packed {
        address_t address;
        bit       value;
    } gpio_event_t;

endpackage

// File: rtl/renode_input_filter.sv
// One-bit debounce: the filtered value follows the raw line only after the
// raw line has disagreed with it for StableCycles consecutive cycles.
module renode_input_filter #(
    parameter int StableCycles = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_filtered
);

    localparam int CntW = ($clog2(StableCycles + 1) > 1) ? $clog2(StableCycles + 1) : 1;

    logic            r_filtered;
    logic [CntW-1:0] r_cnt;

    // Count consecutive disagreement cycles; any agreement restarts the count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_filtered <= 1'b0;
            r_cnt      <= '0;
        end else if (i_raw == r_filtered) begin
            r_cnt <= '0;
        end else if (r_cnt + CntW'(1) == CntW'(StableCycles)) begin
            r_filtered <= i_raw;
            r_cnt      <= '0;
        end else begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

    assign o_filtered = r_filtered;

endmodule

// File: rtl/renode_input_event_encoder.sv
// Debounces a vector of GPIO lines and emits one (index, value) record per
// filtered change over valid/ready. Changes are tracked as a pending mask
// (filtered vs last launched), so a line that flips back before launch is
// coalesced away.
module renode_input_event_encoder
    import renode_pkg::*;
#(
    parameter int InputsCount  = 1,
    parameter int StableCycles = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [InputsCount-1:0] inputs,
    input  logic                   enable,
    output logic                   event_valid,
    input  logic                   event_ready,
    output address_t               event_address,
    output logic                   event_value
);

    localparam int PtrW = (InputsCount > 1) ? $clog2(InputsCount) : 1;

    logic [InputsCount-1:0] w_filt;
    logic [InputsCount-1:0] w_pend;
    logic [InputsCount-1:0] r_last;
    logic [PtrW-1:0]        r_rr_ptr;
    logic [PtrW-1:0]        w_sel;
    logic [PtrW-1:0]        w_next_ptr;
    logic                   w_found;
    logic                   w_free;
    logic                   w_launch;
    logic                   r_valid;
    address_t               r_address;
    logic                   r_value;

    genvar gi;
    generate
        for (gi = 0; gi < InputsCount; gi++) begin : g_filt
            renode_input_filter #(
                .StableCycles(StableCycles)
            ) u_filt (
                .i_clk     (clk),
                .i_rst     (rst),
                .i_raw     (inputs[gi]),
                .o_filtered(w_filt[gi])
            );
        end
    endgenerate

    assign w_pend = w_filt ^ r_last;

    // Round-robin pick: first pending index at or above rr_ptr, wrapping.
    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < InputsCount; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= InputsCount) idx = idx - InputsCount;
            if (!w_found && w_pend[idx]) begin
                w_found = 1'b1;
                w_sel   = PtrW'(idx);
            end
        end
    end

    assign w_next_ptr = (w_sel == PtrW'(InputsCount - 1)) ? '0 : w_sel + PtrW'(1);
    // Ready only opens the slot; the launched data never depends on it.
    assign w_free     = !r_valid || event_ready;
    assign w_launch   = w_free && enable && w_found;

    // Output slot: load a new record when free, otherwise hold it stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_address <= '0;
            r_value   <= 1'b0;
            r_last    <= '0;
            r_rr_ptr  <= '0;
        end else if (w_launch) begin
            r_valid       <= 1'b1;
            r_address     <= address_t'(w_sel);
            r_value       <= w_filt[w_sel];
            r_last[w_sel] <= w_filt[w_sel];
            r_rr_ptr      <= w_next_ptr;
        end else if (w_free) begin
            r_valid <= 1'b0;
        end
    end

    assign event_valid   = r_valid;
    assign event_address = r_address;
    assign event_value   = r_value;

endmodule

// File: tb/tb_renode_input_event_encoder.sv
// Directed bench: dut1 (4 inputs, StableCycles=1) and dut3 (4 inputs,
// StableCycles=3), expected records hand-computed per clock edge.
module tb_renode_input_event_encoder;

    logic        clk = 1'b0;
    logic        rst1, rst3;
    logic [3:0]  in1, in3;
    logic        en1, rdy1, rdy3;
    logic        ev1, ev3;
    logic [63:0] ea1, ea3;
    logic        eval1, eval3;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    renode_input_event_encoder #(.InputsCount(4), .StableCycles(1)) dut1 (
        .clk(clk), .rst(rst1), .inputs(in1), .enable(en1),
        .event_valid(ev1), .event_ready(rdy1),
        .event_address(ea1), .event_value(eval1));

    renode_input_event_encoder #(.InputsCount(4), .StableCycles(3)) dut3 (
        .clk(clk), .rst(rst3), .inputs(in3), .enable(1'b1),
        .event_valid(ev3), .event_ready(rdy3),
        .event_address(ea3), .event_value(eval3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // sel=1 checks dut1, otherwise dut3. Address/value are only checked
    // when a record is expected.
    task automatic chk(string tag, int sel, logic v, int a, logic val);
        logic        gv, gval;
        logic [63:0] ga;
        gv   = (sel == 1) ? ev1 : ev3;
        ga   = (sel == 1) ? ea1 : ea3;
        gval = (sel == 1) ? eval1 : eval3;
        checks++;
        assert (gv === v) else begin
            failures++;
            $error("FAIL %s valid got=%0b exp=%0b", tag, gv, v);
        end
        if (v) begin
            checks++;
            assert (ga === 64'(a)) else begin
                failures++;
                $error("FAIL %s address got=%0d exp=%0d", tag, ga, a);
            end
            checks++;
            assert (gval === val) else begin
                failures++;
                $error("FAIL %s value got=%0b exp=%0b", tag, gval, val);
            end
        end
    endtask

    initial begin
        rst1 = 1'b1; rst3 = 1'b1; in1 = '0; in3 = '0;
        en1 = 1'b1; rdy1 = 1'b1; rdy3 = 1'b1;
        tick(); tick(); tick();
        checks++;
        assert ({ev1, ea1, eval1} === 66'd0) else begin
            failures++;
            $error("FAIL reset_state got=%0h exp=0", {ev1, ea1, eval1});
        end
        rst1 = 1'b0; rst3 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(); chk("idle1", 1, 0, 0, 0); chk("idle3", 3, 0, 0, 0);
        end

        // Single rise then fall on input 2, two-edge latency.
        in1[2] = 1'b1;
        tick(); chk("r2_filt", 1, 0, 0, 0);
        tick(); chk("r2_ev", 1, 1, 2, 1);
        tick(); chk("r2_once", 1, 0, 0, 0);
        tick(); tick(); tick(); chk("r2_quiet", 1, 0, 0, 0);
        in1[2] = 1'b0;
        tick(); chk("f2_filt", 1, 0, 0, 0);
        tick(); chk("f2_ev", 1, 1, 2, 0);
        tick(); chk("f2_once", 1, 0, 0, 0);

        // StableCycles=3: short pulse dropped, 3-cycle pulse passes.
        in3[0] = 1'b1;
        tick(); chk("p2_a", 3, 0, 0, 0);
        tick(); chk("p2_b", 3, 0, 0, 0);
        in3[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(); chk("p2_none", 3, 0, 0, 0);
        end
        in3[0] = 1'b1;
        tick(); chk("p3_e1", 3, 0, 0, 0);
        tick(); chk("p3_e2", 3, 0, 0, 0);
        tick(); chk("p3_e3", 3, 0, 0, 0);
        in3[0] = 1'b0;
        tick(); chk("p3_rise", 3, 1, 0, 1);
        tick(); chk("p3_e5", 3, 0, 0, 0);
        tick(); chk("p3_e6", 3, 0, 0, 0);
        tick(); chk("p3_fall", 3, 1, 0, 0);
        tick(); chk("p3_done", 3, 0, 0, 0);

        // Round robin from rr_ptr=0 after a fresh reset.
        rst1 = 1'b1; tick(); tick(); rst1 = 1'b0;
        in1 = 4'b1111;
        tick(); chk("all_filt", 1, 0, 0, 0);
        tick(); chk("all_0", 1, 1, 0, 1);
        tick(); chk("all_1", 1, 1, 1, 1);
        tick(); chk("all_2", 1, 1, 2, 1);
        tick(); chk("all_3", 1, 1, 3, 1);
        tick(); chk("all_end", 1, 0, 0, 0);
        in1 = 4'b0000;
        tick(); chk("none_filt", 1, 0, 0, 0);
        tick(); chk("none_0", 1, 1, 0, 0);
        tick(); chk("none_1", 1, 1, 1, 0);
        tick(); chk("none_2", 1, 1, 2, 0);
        tick(); chk("none_3", 1, 1, 3, 0);
        tick(); chk("none_end", 1, 0, 0, 0);
        // Move rr_ptr to 1 via a pulse on input 0.
        in1 = 4'b0001;
        tick(); tick(); chk("ptr_r0", 1, 1, 0, 1);
        tick(); in1 = 4'b0000;
        tick(); tick(); chk("ptr_f0", 1, 1, 0, 0);
        tick(); chk("ptr_end", 1, 0, 0, 0);
        in1 = 4'b1001;
        tick(); chk("rr_filt", 1, 0, 0, 0);
        tick(); chk("rr_first3", 1, 1, 3, 1);
        tick(); chk("rr_then0", 1, 1, 0, 1);
        tick(); chk("rr_end", 1, 0, 0, 0);

        // Backpressure: held record stays put, later change re-pends.
        rdy1 = 1'b0; in1[1] = 1'b1;
        tick(); chk("bp_filt", 1, 0, 0, 0);
        tick(); chk("bp_ev", 1, 1, 1, 1);
        in1[1] = 1'b0;
        tick(); chk("bp_hold1", 1, 1, 1, 1);
        tick(); chk("bp_hold2", 1, 1, 1, 1);
        tick(); chk("bp_hold3", 1, 1, 1, 1);
        rdy1 = 1'b1;
        tick(); chk("bp_next", 1, 1, 1, 0);
        tick(); chk("bp_end", 1, 0, 0, 0);

        // Clear inputs 0 and 3 (rr_ptr=2 -> 3 first).
        in1 = 4'b0000;
        tick(); tick(); chk("clr_3", 1, 1, 3, 0);
        tick(); chk("clr_0", 1, 1, 0, 0);
        tick(); chk("clr_end", 1, 0, 0, 0);

        // Enable low: input 0 pulse coalesced, only {2,1} survives.
        en1 = 1'b0; in1 = 4'b0101;
        tick(); tick(); tick(); chk("en_off_a", 1, 0, 0, 0);
        in1 = 4'b0100;
        tick(); tick(); tick(); chk("en_off_b", 1, 0, 0, 0);
        en1 = 1'b1;
        tick(); chk("en_on", 1, 1, 2, 1);
        tick(); chk("en_only", 1, 0, 0, 0);

        // Reset mid-handshake drops the record.
        rdy1 = 1'b0; in1[1] = 1'b1;
        tick(); tick(); chk("rst_pre", 1, 1, 1, 1);
        rst1 = 1'b1;
        tick(); chk("rst_drop", 1, 0, 0, 0);
        rst1 = 1'b0; rdy1 = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/renode_input_event_encoder.md
# renode_input_event_encoder

Synthesizable transmitter for GPIO state changes headed to Renode. The block debounces a vector of DUT-driven inputs and turns every change of a filtered input into one event record `(index, value)`. Records leave on a valid/ready handshake and map directly onto a Renode `interrupt` message (`address` = index, `data[0]` = value). It sits between DUT interrupt/GPIO lines and the co-simulation message sender, and is the counterpart of the output path that applies `interrupt` messages to `renode_outputs`.

## Interface
- `InputsCount`, 1: number of monitored inputs; must be ≥ 1.
- `StableCycles`, 1: consecutive cycles a raw input must differ from its filtered value before the filtered value follows; must be ≥ 1.
- `clk` input 1: sole clock; all state updates on posedge.
- `rst` input 1: synchronous, active-high reset.
- `inputs` input `InputsCount`: raw DUT lines, already synchronous to `clk`.
- `enable` input 1: 0 blocks launching new events; filtering continues.
- `event_valid` output 1: event record is present.
- `event_ready` input 1: consumer accepts the record.
- `event_address` output 64 (`renode_pkg::address_t`): index of the input that changed, zero-extended.
- `event_value` output 1: new filtered value of that input.

## Operation
- **Per-input filter state.** `filtered[i]` and counter `cnt[i]`; counter width `max($clog2(StableCycles+1),1)`.
  - `inputs[i] == filtered[i]`: `cnt <= 0`.
  - Otherwise, `cnt+1 == StableCycles`: `filtered <= inputs`, `cnt <= 0`.
  - Otherwise: `cnt <= cnt+1`.
  - A pulse shorter than `StableCycles` cycles is discarded.
- **Pending set.** `last_reported[i]` holds the value most recently launched for input i. Pending mask `P = filtered ^ last_reported`. No separate queue exists, so an input that toggles back before it is launched produces no event (coalescing).
- **Output slot.** The slot is free when `!event_valid || event_ready`. When free, `enable` is 1 and `P != 0`:
  - Select the first set bit of `P` scanning from `rr_ptr` upward, wrapping at `InputsCount-1` to 0.
  - Load `event_address <= index`, `event_value <= filtered[index]`, `event_valid <= 1`.
  - Update `last_reported[index] <= filtered[index]` and `rr_ptr <= index+1` (wraps to 0 past `InputsCount-1`).
- **Slot free, nothing launched** (because `P == 0` or `enable == 0`): `event_valid <= 0`.
- **Held record.** While `event_valid && !event_ready`, `event_address` and `event_value` stay stable even if the input changes again. The later change then shows up in `P` after acceptance.
- **Filter update and launch on the same input in the same cycle.** Launch uses the pre-edge `filtered` value. The post-edge mismatch re-pends the input.
- **`enable` low during a held record.** The held record stays valid until accepted.
- **Reset.** All of the following are 0: `filtered`, `cnt`, `last_reported`, `rr_ptr`, `event_valid`, `event_address`, `event_value`. Inputs that are high when reset releases therefore produce events. `rst` asserted mid-handshake drops the record with no acceptance.

## Timing
- `StableCycles=1`: `inputs` changes before edge k, `filtered` updates at edge k, `event_valid` rises at edge k+1. Latency is 2 edges.
- General case: `event_valid` rises at edge k+StableCycles.
- Throughput is one event per cycle while `event_ready` is held at 1.
- The handshake completes on any edge where `event_valid && event_ready`.
- No combinational path from `event_ready` to the output data; `event_ready` only gates the slot-free term.

## Structure
- Reuse `renode_pkg::address_t`.
- Add `renode_pkg::gpio_event_t` (packed struct: `address_t address; bit value;`) for consumers.
- Keep the counter width as a localparam in the module.
- Sub-module `renode_input_filter`: one-bit debounce holding `filtered` and `cnt`, instantiated `InputsCount` times via generate.
- Round-robin selection, `last_reported` and the output slot stay in the top module.

## Test plan
- Reset with `InputsCount=4`, `StableCycles=1`, inputs 0 → after release, `event_valid` stays 0 for 10 cycles.
- Raise `inputs[2]` with ready=1 → exactly one record `{address 2, value 1}` at edge k+1; lower it 5 cycles later → `{2, 0}`.
- `StableCycles=3`: 2-cycle high pulse on `inputs[0]` → no event; 3-cycle pulse → `{0,1}` then `{0,0}`.
- All four inputs rise together, `rr_ptr=0` → records with indices 0, 1, 2, 3 on consecutive cycles; then raise `inputs[0]` and `inputs[3]` with `rr_ptr=1` → order 3, then 0.
- Ready held 0 with `{1,1}` pending, then `inputs[1]` toggles 1→0 → record stays `{1,1}`; after acceptance one further `{1,0}` record appears.
- `enable=0` while inputs 0 and 2 rise and input 0 falls back → no events; on `enable=1` only `{2,1}` is emitted.
